// File: rtl/riscv_muldiv_arbiter_if.sv
// Bundle between the muldiv arbiter and its environment: two requesters,
// the response port, pipeline flush and the coprocessor control/response pins.
interface riscv_muldiv_arbiter_if;
    logic        req0_valid;
    logic [2:0]  req0_subop;
    logic [31:0] req0_rs1;
    logic [31:0] req0_rs2;
    logic        req0_ack;

    logic        req1_valid;
    logic [2:0]  req1_subop;
    logic [31:0] req1_rs1;
    logic [31:0] req1_rs2;
    logic        req1_ack;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_error;

    logic        flush;
    logic        busy;

    logic        cp_dec_valid;
    logic [3:0]  cp_dec_subop;
    logic        cp_alu_valid;
    logic [31:0] cp_alu_rs1;
    logic [31:0] cp_alu_rs2;
    logic        cp_alu_flush;
    logic        cp_cannot_start;
    logic        cp_cannot_complete;
    logic        cp_result_valid;
    logic [31:0] cp_result;

    // arbiter side
    modport slave (
        input  req0_valid, req0_subop, req0_rs1, req0_rs2,
        output req0_ack,
        input  req1_valid, req1_subop, req1_rs1, req1_rs2,
        output req1_ack,
        output rsp_valid, rsp_id, rsp_result, rsp_error,
        input  rsp_ready,
        input  flush,
        output busy,
        output cp_dec_valid, cp_dec_subop, cp_alu_valid, cp_alu_rs1, cp_alu_rs2, cp_alu_flush,
        input  cp_cannot_start, cp_cannot_complete, cp_result_valid, cp_result
    );

    // requesters, response consumer and coprocessor side
    modport master (
        output req0_valid, req0_subop, req0_rs1, req0_rs2,
        input  req0_ack,
        output req1_valid, req1_subop, req1_rs1, req1_rs2,
        input  req1_ack,
        input  rsp_valid, rsp_id, rsp_result, rsp_error,
        output rsp_ready,
        output flush,
        input  busy,
        input  cp_dec_valid, cp_dec_subop, cp_alu_valid, cp_alu_rs1, cp_alu_rs2, cp_alu_flush,
        output cp_cannot_start, cp_cannot_complete, cp_result_valid, cp_result
    );
endinterface

// File: rtl/riscv_muldiv_arbiter.sv
// Round-robin sharing of one muldiv coprocessor between two requesters, with
// stall handshake, completion timeout and pipeline flush.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | no op in flight; grants the next requester
//   S_DECODE| latched subop presented to the coprocessor decode stage
//   S_EXEC  | operands presented to the ALU stage, waiting for a start
//   S_WAIT  | coprocessor accepted the op but cannot complete yet
//   S_RESP  | tagged response held until the consumer accepts it
module riscv_muldiv_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    riscv_muldiv_arbiter_if.slave bus
);
    localparam int            TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_WAIT, S_RESP} state_t;

    state_t        state;
    logic          last_grant;
    logic          id_q;
    logic [2:0]    subop_q;
    logic [31:0]   rs1_q;
    logic [31:0]   rs2_q;
    logic [31:0]   result_q;
    logic          error_q;
    logic [TW-1:0] timer;

    logic          in_alu;
    logic          in_op;
    logic [TW-1:0] timer_inc;
    logic          flush_hit;
    logic          timeout_hit;
    logic          grant;
    logic          grant_id;

    assign in_alu    = (state == S_EXEC) || (state == S_WAIT);
    assign in_op     = in_alu || (state == S_DECODE);
    assign timer_inc = (timer == {TW{1'b1}}) ? timer : timer + TW'(1);
    assign flush_hit = in_op && bus.flush;
    // timer_inc counts the current cycle, so the abort lands on the Nth EXEC/WAIT cycle
    assign timeout_hit = in_alu && (timer_inc >= TIMEOUT_VAL);

    assign grant    = (state == S_IDLE) && (bus.req0_valid || bus.req1_valid) && !reset;
    assign grant_id = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;

    assign bus.req0_ack     = grant && !grant_id;
    assign bus.req1_ack     = grant && grant_id;
    assign bus.busy         = (state != S_IDLE);
    assign bus.cp_dec_valid = (state == S_DECODE);
    assign bus.cp_dec_subop = {1'b0, subop_q};
    assign bus.cp_alu_valid = in_alu;
    assign bus.cp_alu_rs1   = rs1_q;
    assign bus.cp_alu_rs2   = rs2_q;
    assign bus.cp_alu_flush = !reset && (flush_hit || timeout_hit);
    assign bus.rsp_valid    = (state == S_RESP);
    assign bus.rsp_id       = id_q;
    assign bus.rsp_result   = result_q;
    assign bus.rsp_error    = error_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            subop_q    <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            result_q   <= '0;
            error_q    <= 1'b0;
            timer      <= '0;
        end else if (flush_hit) begin
            state <= S_IDLE;
            timer <= '0;
        end else if (timeout_hit) begin
            result_q <= '0;
            error_q  <= 1'b1;
            timer    <= timer_inc;
            state    <= S_RESP;
        end else begin
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (grant) begin
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        subop_q    <= grant_id ? bus.req1_subop : bus.req0_subop;
                        rs1_q      <= grant_id ? bus.req1_rs1 : bus.req0_rs1;
                        rs2_q      <= grant_id ? bus.req1_rs2 : bus.req0_rs2;
                        state      <= S_DECODE;
                    end
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    timer <= timer_inc;
                    if (!bus.cp_cannot_start) begin
                        if (bus.cp_cannot_complete) begin
                            state <= S_WAIT;
                        end else begin
                            // no start, no stall and no result is a protocol violation
                            result_q <= bus.cp_result_valid ? bus.cp_result : '0;
                            error_q  <= !bus.cp_result_valid;
                            state    <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    timer <= timer_inc;
                    if (!bus.cp_cannot_complete) begin
                        result_q <= bus.cp_result_valid ? bus.cp_result : '0;
                        error_q  <= !bus.cp_result_valid;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        timer <= '0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_muldiv_arbiter.sv
// Directed bench for the muldiv arbiter: the bench plays both requesters,
// the response consumer and a cycle-scripted coprocessor.
module tb_riscv_muldiv_arbiter;
    logic clk;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   alu_cnt = 0;
    int   rsp_cnt = 0;

    riscv_muldiv_arbiter_if bus ();

    riscv_muldiv_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.cp_alu_valid) alu_cnt <= alu_cnt + 1;
        if (bus.rsp_valid && bus.rsp_ready) rsp_cnt <= rsp_cnt + 1;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input int rid, input logic [2:0] sub, input logic [31:0] a, b);
        if (rid == 0) begin
            bus.req0_valid = 1'b1; bus.req0_subop = sub; bus.req0_rs1 = a; bus.req0_rs2 = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_subop = sub; bus.req1_rs1 = a; bus.req1_rs2 = b;
        end
    endtask

    // From the DECODE cycle of a granted op up to the IDLE cycle after the response.
    task automatic run_rest(input int rid, input logic [2:0] sub, input logic [31:0] a, b,
                            input int n_cs, input int n_cc, input logic give_rv,
                            input logic [31:0] res, input logic [31:0] exp_res,
                            input logic exp_err, input int n_stall, input string tag);
        @(negedge clk);
        if (rid == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
        #1;
        check_eq({tag, "_dec_valid"}, bus.cp_dec_valid, 1);
        check_eq({tag, "_dec_subop"}, bus.cp_dec_subop, {29'd0, sub});
        check_eq({tag, "_alu_idle"}, bus.cp_alu_valid, 0);
        for (int i = 0; i < n_cs + n_cc + 1; i++) begin
            @(negedge clk);
            bus.cp_cannot_start    = (i < n_cs);
            bus.cp_cannot_complete = (i >= n_cs) && (i < n_cs + n_cc);
            bus.cp_result_valid    = (i == n_cs + n_cc) && give_rv;
            bus.cp_result          = (i == n_cs + n_cc) ? res : 32'h0;
            #1;
            check_eq({tag, "_alu_valid"}, bus.cp_alu_valid, 1);
            check_eq({tag, "_alu_rs1"}, bus.cp_alu_rs1, a);
            check_eq({tag, "_alu_rs2"}, bus.cp_alu_rs2, b);
            check_eq({tag, "_alu_flush"}, bus.cp_alu_flush, 0);
        end
        @(negedge clk);
        bus.cp_cannot_start = 0; bus.cp_cannot_complete = 0;
        bus.cp_result_valid = 0; bus.cp_result = 0;
        for (int s = 0; s <= n_stall; s++) begin
            if (s > 0) @(negedge clk);
            #1;
            check_eq({tag, "_rsp_valid"}, bus.rsp_valid, 1);
            check_eq({tag, "_rsp_id"}, bus.rsp_id, rid);
            check_eq({tag, "_rsp_result"}, bus.rsp_result, exp_res);
            check_eq({tag, "_rsp_error"}, bus.rsp_error, exp_err);
            check_eq({tag, "_no_ack_in_resp"}, bus.req0_ack | bus.req1_ack, 0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        check_eq({tag, "_rsp_done"}, bus.rsp_valid, 0);
        check_eq({tag, "_idle"}, bus.busy, 0);
    endtask

    task automatic do_op(input int rid, input logic [2:0] sub, input logic [31:0] a, b,
                         input int n_cs, input int n_cc, input logic give_rv,
                         input logic [31:0] res, input logic [31:0] exp_res,
                         input logic exp_err, input int n_stall, input string tag);
        @(negedge clk);
        drive_req(rid, sub, a, b);
        #1;
        check_eq({tag, "_ack"}, (rid == 0) ? bus.req0_ack : bus.req1_ack, 1);
        check_eq({tag, "_ack_other"}, (rid == 0) ? bus.req1_ack : bus.req0_ack, 0);
        run_rest(rid, sub, a, b, n_cs, n_cc, give_rv, res, exp_res, exp_err, n_stall, tag);
    endtask

    initial begin
        int a0, r0;
        reset = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_subop = 0; bus.req0_rs1 = 0; bus.req0_rs2 = 0;
        bus.req1_valid = 1'b0; bus.req1_subop = 0; bus.req1_rs1 = 0; bus.req1_rs2 = 0;
        bus.rsp_ready = 0; bus.flush = 1'b1;
        bus.cp_cannot_start = 0; bus.cp_cannot_complete = 0;
        bus.cp_result_valid = 0; bus.cp_result = 0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_ack0", bus.req0_ack, 0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_dec_valid", bus.cp_dec_valid, 0);
        check_eq("rst_alu_valid", bus.cp_alu_valid, 0);
        check_eq("rst_alu_flush", bus.cp_alu_flush, 0);
        check_eq("rst_rsp_result", bus.rsp_result, 0);
        @(negedge clk);
        reset = 1'b0; bus.req0_valid = 1'b0; bus.flush = 1'b0;

        // MUL 6*7 with three cannot_complete cycles
        do_op(0, 3'd0, 32'd6, 32'd7, 0, 3, 1'b1, 32'd42, 32'd42, 1'b0, 0, "mul");
        // no start, no stall, no result: protocol error
        do_op(0, 3'd2, 32'd1, 32'd1, 0, 0, 1'b0, 32'h55, 32'd0, 1'b1, 0, "proto");

        // cannot_start for two cycles: REM -7 % 2 = -1
        a0 = alu_cnt; r0 = rsp_cnt;
        do_op(1, 3'd6, 32'hFFFF_FFF9, 32'd2, 2, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "rem");
        check_eq("rem_alu_cycles", alu_cnt - a0, 3);
        check_eq("rem_rsp_count", rsp_cnt - r0, 1);

        // timeout: abort on the 8th EXEC/WAIT cycle even though a result shows up then
        @(negedge clk);
        drive_req(1, 3'd3, 32'hFFFF_FFFF, 32'd2);
        #1 check_eq("to_ack", bus.req1_ack, 1);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bus.cp_cannot_complete = (k < 8);
            bus.cp_result_valid    = (k == 8);
            bus.cp_result          = (k == 8) ? 32'hDEAD_BEEF : 32'h0;
            #1;
            check_eq($sformatf("to_alu_flush_c%0d", k), bus.cp_alu_flush, (k == 8));
            check_eq($sformatf("to_alu_valid_c%0d", k), bus.cp_alu_valid, 1);
        end
        @(negedge clk);
        bus.cp_cannot_complete = 0; bus.cp_result_valid = 0; bus.cp_result = 0;
        #1;
        check_eq("to_rsp_valid", bus.rsp_valid, 1);
        check_eq("to_rsp_error", bus.rsp_error, 1);
        check_eq("to_rsp_result", bus.rsp_result, 0);
        check_eq("to_rsp_id", bus.rsp_id, 1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1 check_eq("to_idle", bus.busy, 0);

        // flush in WAIT from requester 0
        r0 = rsp_cnt;
        @(negedge clk);
        drive_req(0, 3'd1, 32'd5, 32'd9);
        #1 check_eq("fl_ack0", bus.req0_ack, 1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        bus.cp_cannot_complete = 1'b1;
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check_eq("fl_alu_flush", bus.cp_alu_flush, 1);
        check_eq("fl_alu_valid", bus.cp_alu_valid, 1);
        @(negedge clk);
        bus.flush = 1'b0; bus.cp_cannot_complete = 1'b0;
        #1;
        check_eq("fl_busy", bus.busy, 0);
        check_eq("fl_rsp_valid", bus.rsp_valid, 0);
        // last grant is now 0, so requester 1 wins the tie
        drive_req(0, 3'd0, 32'd3, 32'd5);
        drive_req(1, 3'd5, 32'd100, 32'd7);
        #1;
        check_eq("fl_rr_ack1", bus.req1_ack, 1);
        check_eq("fl_rr_ack0", bus.req0_ack, 0);
        // DIVU 100/7 held in RESP 5 cycles while requester 0 waits
        run_rest(1, 3'd5, 32'd100, 32'd7, 0, 0, 1'b1, 32'd14, 32'd14, 1'b0, 5, "divu");
        check_eq("fl_rsp_count", rsp_cnt - r0, 1);
        check_eq("stall_then_ack0", bus.req0_ack, 1);
        run_rest(0, 3'd0, 32'd3, 32'd5, 0, 1, 1'b1, 32'd15, 32'd15, 1'b0, 0, "mul35");

        // reset in WAIT together with flush
        @(negedge clk);
        drive_req(1, 3'd4, 32'd50, 32'd5);
        #1 check_eq("rw_ack1", bus.req1_ack, 1);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        bus.cp_cannot_complete = 1'b1;
        @(negedge clk);
        reset = 1'b1; bus.flush = 1'b1;
        #1 check_eq("rw_no_flush_pulse", bus.cp_alu_flush, 0);
        @(negedge clk);
        reset = 1'b0; bus.flush = 1'b0; bus.cp_cannot_complete = 1'b0;
        #1;
        check_eq("rw_busy", bus.busy, 0);
        check_eq("rw_alu_valid", bus.cp_alu_valid, 0);
        check_eq("rw_alu_rs1", bus.cp_alu_rs1, 0);
        check_eq("rw_dec_subop", bus.cp_dec_subop, 0);
        check_eq("rw_rsp_result", bus.rsp_result, 0);
        check_eq("rw_rsp_valid", bus.rsp_valid, 0);

        // contention from reset: grants alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_req(0, 3'd0, 32'h1111, 32'd3);
            drive_req(1, 3'd3, 32'h2222, 32'd4);
            #1;
            check_eq($sformatf("rr%0d_ack0", i), bus.req0_ack, (i % 2 == 0));
            check_eq($sformatf("rr%0d_ack1", i), bus.req1_ack, (i % 2 == 1));
            @(negedge clk);
            #1 check_eq($sformatf("rr%0d_subop", i), bus.cp_dec_subop, (i % 2 == 0) ? 0 : 3);
            @(negedge clk);
            bus.cp_result_valid = 1'b1; bus.cp_result = 32'd100 + 32'(i);
            #1 check_eq($sformatf("rr%0d_rs1", i), bus.cp_alu_rs1, (i % 2 == 0) ? 32'h1111 : 32'h2222);
            @(negedge clk);
            bus.cp_result_valid = 1'b0; bus.cp_result = 0;
            #1;
            check_eq($sformatf("rr%0d_rsp_id", i), bus.rsp_id, i % 2);
            check_eq($sformatf("rr%0d_rsp_result", i), bus.rsp_result, 32'd100 + 32'(i));
            check_eq($sformatf("rr%0d_no_ack", i), bus.req0_ack | bus.req1_ack, 0);
            bus.rsp_ready = 1'b1;
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        #1 check_eq("rr_end_idle", bus.busy, 0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
